// File: rtl/ika32010_busmem_pkg.sv
// ---------------------------------------------------------------------------
// ika32010_busmem_pkg
// Shared constants and the bus-operation decode type for the IKA32010
// external bus responder.
//   IO_ADDR_LIMIT : addresses below this value select an I/O port on writes
//   PORT_SEL_W    : width of the port-select field taken from the address LSBs
//   DATA_W        : core data bus width
//   bus_op_e      : decoded bus activity for one cycle
// ---------------------------------------------------------------------------
package ika32010_busmem_pkg;

    localparam int IO_ADDR_LIMIT = 8;
    localparam int PORT_SEL_W    = 3;
    localparam int DATA_W        = 16;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_FETCH,
        BUS_IN,
        BUS_OUT,
        BUS_TBLW
    } bus_op_e;

endpackage

// File: rtl/ika32010_busmem_fifo.sv
// ---------------------------------------------------------------------------
// ika32010_busmem_fifo
// Single-clock FIFO with a combinational head word.
//   clk, rst_n : clock and synchronous active-low reset
//   push/wdata : write request and data; accepted when not full, or when a
//                pop happens in the same cycle
//   pop        : read request; ignored when empty
//   head       : word at the read pointer (valid when empty is low)
//   full/empty : registered-count status, valid the cycle after an update
// ---------------------------------------------------------------------------
module ika32010_busmem_fifo
    import ika32010_busmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a push on a full FIFO
    // alongside a pop is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays are deliberately not reset; the pointers and count
    // define validity, and an unreset array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ika32010_busmem.sv
// ---------------------------------------------------------------------------
// ika32010_busmem
// External bus responder for the IKA32010 core: program memory plus a bank
// of FIFO-backed I/O ports, driven by the core's MEN_n/DEN_n/WE_n strobes.
//   i_EMUCLK, i_RST_n          : clock, synchronous active-low reset
//   i_MEN_n/i_DEN_n/i_WE_n     : core memory, data-in and write strobes
//   i_AOUT, i_DOUT             : core address and write data
//   o_DIN, o_DIN_OE            : read data and read-data enable to the core
//   i_HOST_WR/_PORT/_WDATA     : host push into a port's input FIFO
//   i_HOST_RD/_PORT, o_HOST_RDATA : host pop from a port's output FIFO
//   o_IN_FULL, o_OUT_EMPTY     : per-port FIFO status
//   o_IN_UNDERRUN, o_OUT_OVERRUN, i_HOST_CLR_ERR : sticky error flags
//   i_PLD_WR/_ADDR/_DATA       : host program-memory load (any state)
// ---------------------------------------------------------------------------
module ika32010_busmem
    import ika32010_busmem_pkg::*;
#(
    parameter int    AW         = 12,
    parameter int    PMEM_DEPTH = 4096,
    parameter int    PORTS      = 8,
    parameter int    FIFO_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_RST_n,
    input  logic                  i_MEN_n,
    input  logic                  i_DEN_n,
    input  logic                  i_WE_n,
    input  logic [AW-1:0]         i_AOUT,
    input  logic [DATA_W-1:0]     i_DOUT,
    output logic [DATA_W-1:0]     o_DIN,
    output logic                  o_DIN_OE,
    input  logic                  i_HOST_WR,
    input  logic [PORT_SEL_W-1:0] i_HOST_WR_PORT,
    input  logic [DATA_W-1:0]     i_HOST_WDATA,
    input  logic                  i_HOST_RD,
    input  logic [PORT_SEL_W-1:0] i_HOST_RD_PORT,
    output logic [DATA_W-1:0]     o_HOST_RDATA,
    output logic [PORTS-1:0]      o_IN_FULL,
    output logic [PORTS-1:0]      o_OUT_EMPTY,
    output logic [PORTS-1:0]      o_IN_UNDERRUN,
    output logic [PORTS-1:0]      o_OUT_OVERRUN,
    input  logic                  i_HOST_CLR_ERR,
    input  logic                  i_PLD_WR,
    input  logic [AW-1:0]         i_PLD_ADDR,
    input  logic [DATA_W-1:0]     i_PLD_DATA
);

    localparam int            PA_W       = (PMEM_DEPTH > 1) ? $clog2(PMEM_DEPTH) : 1;
    localparam logic [AW:0]   PMEM_LIMIT = (AW + 1)'(PMEM_DEPTH);
    localparam logic [AW-1:0] IO_LIMIT   = AW'(IO_ADDR_LIMIT);

    // ------------------------------------------------------------------
    // Strobe edge detection
    // ------------------------------------------------------------------
    // Previous-cycle registers reset to 0 (asserted), so a strobe that is
    // already low when reset releases never produces a falling edge.
    logic den_q;
    logic we_q;
    logic we_armed;
    logic den_fall;
    logic we_fall;
    logic we_rise;
    logic commit;

    assign den_fall = den_q & ~i_DEN_n;
    assign we_fall  = we_q & ~i_WE_n;
    assign we_rise  = ~we_q & i_WE_n;
    // A write commits only if its falling edge was seen after reset; a
    // pulse that straddles reset is thereby aborted.
    assign commit   = we_rise & we_armed;

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            den_q    <= 1'b0;
            we_q     <= 1'b0;
            we_armed <= 1'b0;
        end else begin
            den_q <= i_DEN_n;
            we_q  <= i_WE_n;
            if (we_fall)      we_armed <= 1'b1;
            else if (we_rise) we_armed <= 1'b0;
        end
    end

    // Write data is the value present during the last low cycle of WE_n.
    logic [DATA_W-1:0] wdata_q;
    always_ff @(posedge i_EMUCLK) begin
        if (!i_WE_n) wdata_q <= i_DOUT;
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [PORT_SEL_W-1:0] port_sel;
    logic                  is_io;
    logic                  addr_ok;
    logic                  pld_ok;
    bus_op_e               wr_op;
    bus_op_e               rd_src;

    assign port_sel = i_AOUT[PORT_SEL_W-1:0];
    assign is_io    = (i_AOUT < IO_LIMIT);
    assign addr_ok  = ({1'b0, i_AOUT} < PMEM_LIMIT);
    assign pld_ok   = ({1'b0, i_PLD_ADDR} < PMEM_LIMIT);

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_op = BUS_IDLE;
        if (commit) wr_op = is_io ? BUS_OUT : BUS_TBLW;
    end

    // DEN_n data takes precedence when both read strobes are low.
    always_comb begin
        rd_src = BUS_IDLE;
        if (!i_DEN_n)      rd_src = BUS_IN;
        else if (!i_MEN_n) rd_src = BUS_FETCH;
    end

    // ------------------------------------------------------------------
    // Port FIFOs
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] in_head  [PORTS];
    logic [DATA_W-1:0] out_head [PORTS];
    logic [PORTS-1:0]  in_push, in_pop, in_full, in_empty;
    logic [PORTS-1:0]  out_push, out_pop, out_full, out_empty;
    logic [PORTS-1:0]  under_set, over_set;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        localparam logic [PORT_SEL_W-1:0] PID = PORT_SEL_W'(p);

        assign in_push[p]  = i_HOST_WR & (i_HOST_WR_PORT == PID);
        assign in_pop[p]   = den_fall & (port_sel == PID);
        assign out_push[p] = (wr_op == BUS_OUT) & (port_sel == PID);
        assign out_pop[p]  = i_HOST_RD & (i_HOST_RD_PORT == PID);

        // A full output FIFO still takes the word if the host pops it
        // in the same cycle, so that case is not an overrun.
        assign under_set[p] = in_pop[p] & in_empty[p];
        assign over_set[p]  = out_push[p] & out_full[p] & ~out_pop[p];

        ika32010_busmem_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_in_fifo (
            .clk   (i_EMUCLK),
            .rst_n (i_RST_n),
            .push  (in_push[p]),
            .wdata (i_HOST_WDATA),
            .pop   (in_pop[p]),
            .head  (in_head[p]),
            .full  (in_full[p]),
            .empty (in_empty[p])
        );

        ika32010_busmem_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_out_fifo (
            .clk   (i_EMUCLK),
            .rst_n (i_RST_n),
            .push  (out_push[p]),
            .wdata (wdata_q),
            .pop   (out_pop[p]),
            .head  (out_head[p]),
            .full  (out_full[p]),
            .empty (out_empty[p])
        );
    end

    // Port selects beyond PORTS match no entry and so see an empty,
    // zero-valued port.
    logic              in_avail;
    logic [DATA_W-1:0] in_word;
    always_comb begin
        in_avail     = 1'b0;
        in_word      = '0;
        o_HOST_RDATA = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (port_sel == PORT_SEL_W'(p)) begin
                in_avail = ~in_empty[p];
                in_word  = in_head[p];
            end
            if (i_HOST_RD_PORT == PORT_SEL_W'(p)) o_HOST_RDATA = out_head[p];
        end
    end

    // ------------------------------------------------------------------
    // IN read register and sticky error flags
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_reg;
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            rd_reg        <= '0;
            o_IN_UNDERRUN <= '0;
            o_OUT_OVERRUN <= '0;
        end else begin
            if (den_fall) rd_reg <= in_avail ? in_word : '0;
            // Setting a flag wins over a clear in the same cycle.
            o_IN_UNDERRUN <= (o_IN_UNDERRUN & ~{PORTS{i_HOST_CLR_ERR}}) | under_set;
            o_OUT_OVERRUN <= (o_OUT_OVERRUN & ~{PORTS{i_HOST_CLR_ERR}}) | over_set;
        end
    end

    // ------------------------------------------------------------------
    // Program memory: one write port (host load beats TBLW), one
    // registered read port at the live core address.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] pmem [PMEM_DEPTH];
    logic [DATA_W-1:0] mem_rd_q;

    always_ff @(posedge i_EMUCLK) begin
        if (i_PLD_WR) begin
            if (pld_ok) pmem[i_PLD_ADDR[PA_W-1:0]] <= i_PLD_DATA;
        end else if ((wr_op == BUS_TBLW) && addr_ok) begin
            pmem[i_AOUT[PA_W-1:0]] <= wdata_q;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        mem_rd_q <= addr_ok ? pmem[i_AOUT[PA_W-1:0]] : '0;
    end

    // ------------------------------------------------------------------
    // Core read bus
    // ------------------------------------------------------------------
    always_comb begin
        case (rd_src)
            BUS_IN:    o_DIN = rd_reg;
            BUS_FETCH: o_DIN = mem_rd_q;
            default:   o_DIN = '0;
        endcase
    end

    assign o_DIN_OE    = ~i_MEN_n | ~i_DEN_n;
    assign o_IN_FULL   = in_full;
    assign o_OUT_EMPTY = out_empty;

endmodule

// File: tb/tb_ika32010_busmem.sv
// ---------------------------------------------------------------------------
// tb_ika32010_busmem
// Directed bench for ika32010_busmem: a table of bus/host operations with
// hand-computed results, followed by hand-written multi-cycle sequences.
// Uses PMEM_DEPTH=2048 and PORTS=6 so that out-of-range memory addresses
// and non-existent port numbers can be exercised.
// ---------------------------------------------------------------------------
module tb_ika32010_busmem;

    localparam int AW    = 12;
    localparam int PORTS = 6;
    localparam logic [PORTS-1:0] ALL_ONES = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              men_n, den_n, we_n;
    logic [AW-1:0]     aout;
    logic [15:0]       dout;
    logic [15:0]       din;
    logic              din_oe;
    logic              host_wr;
    logic [2:0]        host_wr_port;
    logic [15:0]       host_wdata;
    logic              host_rd;
    logic [2:0]        host_rd_port;
    logic [15:0]       host_rdata;
    logic [PORTS-1:0]  in_full, out_empty, in_underrun, out_overrun;
    logic              host_clr_err;
    logic              pld_wr;
    logic [AW-1:0]     pld_addr;
    logic [15:0]       pld_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ika32010_busmem #(
        .AW(AW), .PMEM_DEPTH(2048), .PORTS(PORTS), .FIFO_DEPTH(4), .INIT_FILE("")
    ) dut (
        .i_EMUCLK       (clk),
        .i_RST_n        (rst_n),
        .i_MEN_n        (men_n),
        .i_DEN_n        (den_n),
        .i_WE_n         (we_n),
        .i_AOUT         (aout),
        .i_DOUT         (dout),
        .o_DIN          (din),
        .o_DIN_OE       (din_oe),
        .i_HOST_WR      (host_wr),
        .i_HOST_WR_PORT (host_wr_port),
        .i_HOST_WDATA   (host_wdata),
        .i_HOST_RD      (host_rd),
        .i_HOST_RD_PORT (host_rd_port),
        .o_HOST_RDATA   (host_rdata),
        .o_IN_FULL      (in_full),
        .o_OUT_EMPTY    (out_empty),
        .o_IN_UNDERRUN  (in_underrun),
        .o_OUT_OVERRUN  (out_overrun),
        .i_HOST_CLR_ERR (host_clr_err),
        .i_PLD_WR       (pld_wr),
        .i_PLD_ADDR     (pld_addr),
        .i_PLD_DATA     (pld_data)
    );

    typedef enum {V_FETCH, V_HPUSH, V_IN, V_WR, V_HPOP} vop_e;
    typedef struct {
        vop_e        op;
        logic [11:0] addr;  // core address, or port number for host ops
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the same point, well away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_din"},       32'(din),         32'h0);
        check({tag, "_din_oe"},    32'(din_oe),      32'h0);
        check({tag, "_in_full"},   32'(in_full),     32'h0);
        check({tag, "_out_empty"}, 32'(out_empty),   32'(ALL_ONES));
        check({tag, "_underrun"},  32'(in_underrun), 32'h0);
        check({tag, "_overrun"},   32'(out_overrun), 32'h0);
    endtask

    task automatic pld(input logic [11:0] a, input logic [15:0] d);
        pld_wr = 1'b1; pld_addr = a; pld_data = d;
        cyc();
        pld_wr = 1'b0;
    endtask

    task automatic fetch(input logic [11:0] a, input logic [15:0] exp, input string name);
        aout = a; men_n = 1'b0;
        cyc();
        check(name, 32'(din), 32'(exp));
        check({name, "_oe"}, 32'(din_oe), 32'h1);
        men_n = 1'b1;
        cyc();
    endtask

    task automatic host_push(input logic [2:0] p, input logic [15:0] d);
        host_wr = 1'b1; host_wr_port = p; host_wdata = d;
        cyc();
        host_wr = 1'b0;
    endtask

    task automatic host_pop(input logic [2:0] p, input logic [15:0] exp, input string name);
        host_rd_port = p;
        #0;
        check(name, 32'(host_rdata), 32'(exp));
        host_rd = 1'b1;
        cyc();
        host_rd = 1'b0;
    endtask

    task automatic in_pulse(input logic [11:0] a, input logic [15:0] exp, input string name);
        aout = a; den_n = 1'b0;
        cyc();
        check(name, 32'(din), 32'(exp));
        den_n = 1'b1;
        cyc();
    endtask

    task automatic core_write(input logic [11:0] a, input logic [15:0] d);
        aout = a; dout = d; we_n = 1'b0;
        cyc();
        we_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; men_n = 1'b1; den_n = 1'b1; we_n = 1'b1;
        aout = '0; dout = '0;
        host_wr = 1'b0; host_wr_port = '0; host_wdata = '0;
        host_rd = 1'b0; host_rd_port = '0; host_clr_err = 1'b0;
        pld_wr = 1'b0; pld_addr = '0; pld_data = '0;

        // Program load while the core is held in reset.
        cyc();
        pld(12'h000, 16'h7F89);
        pld(12'h001, 16'h7EE0);
        pld(12'h100, 16'h5A5A);
        pld(12'h900, 16'hFFFF);   // beyond PMEM_DEPTH: ignored
        check_reset("reset");
        rst_n = 1'b1;
        cyc();

        vecs.push_back('{V_FETCH, 12'h001, 16'h0000, 16'h7EE0});
        vecs.push_back('{V_FETCH, 12'h000, 16'h0000, 16'h7F89});
        vecs.push_back('{V_HPUSH, 12'h001, 16'h1234, 16'h0000});
        vecs.push_back('{V_HPUSH, 12'h001, 16'h5678, 16'h0000});
        vecs.push_back('{V_IN,    12'h001, 16'h0000, 16'h1234});
        vecs.push_back('{V_IN,    12'h001, 16'h0000, 16'h5678});
        vecs.push_back('{V_IN,    12'h001, 16'h0000, 16'h0000});
        vecs.push_back('{V_WR,    12'h002, 16'h00A0, 16'h0000});
        vecs.push_back('{V_WR,    12'h002, 16'h00A1, 16'h0000});
        vecs.push_back('{V_WR,    12'h002, 16'h00A2, 16'h0000});
        vecs.push_back('{V_WR,    12'h002, 16'h00A3, 16'h0000});
        vecs.push_back('{V_WR,    12'h002, 16'h00A4, 16'h0000});
        vecs.push_back('{V_HPOP,  12'h002, 16'h0000, 16'h00A0});
        vecs.push_back('{V_HPOP,  12'h002, 16'h0000, 16'h00A1});
        vecs.push_back('{V_HPOP,  12'h002, 16'h0000, 16'h00A2});
        vecs.push_back('{V_HPOP,  12'h002, 16'h0000, 16'h00A3});
        vecs.push_back('{V_WR,    12'h042, 16'h4E71, 16'h0000});
        vecs.push_back('{V_FETCH, 12'h042, 16'h0000, 16'h4E71});
        vecs.push_back('{V_FETCH, 12'h100, 16'h0000, 16'h5A5A});
        vecs.push_back('{V_FETCH, 12'h900, 16'h0000, 16'h0000});
        vecs.push_back('{V_IN,    12'h005, 16'h0000, 16'h0000});
        vecs.push_back('{V_IN,    12'h007, 16'h0000, 16'h0000});
        vecs.push_back('{V_WR,    12'h007, 16'h0BAD, 16'h0000});

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d_a%03h", i, vecs[i].addr);
            case (vecs[i].op)
                V_FETCH: fetch(vecs[i].addr, vecs[i].exp, {nm, "_fetch"});
                V_HPUSH: host_push(vecs[i].addr[2:0], vecs[i].data);
                V_IN:    in_pulse(vecs[i].addr, vecs[i].exp, {nm, "_in"});
                V_WR:    core_write(vecs[i].addr, vecs[i].data);
                V_HPOP:  host_pop(vecs[i].addr[2:0], vecs[i].exp, {nm, "_hpop"});
                default: ;
            endcase
        end

        // Port 1 and port 5 underran; port 2 overran; ports 7 (absent) set nothing.
        check("flags_underrun", 32'(in_underrun), 32'h22);
        check("flags_overrun",  32'(out_overrun), 32'h04);
        check("out_empty_after_drain", 32'(out_empty), 32'(ALL_ONES));

        host_clr_err = 1'b1;
        cyc();
        host_clr_err = 1'b0;
        check("clr_underrun", 32'(in_underrun), 32'h0);
        check("clr_overrun",  32'(out_overrun), 32'h0);

        // Set beats clear in the same cycle.
        aout = 12'h003; den_n = 1'b0; host_clr_err = 1'b1;
        cyc();
        host_clr_err = 1'b0;
        check("set_over_clear", 32'(in_underrun), 32'h08);
        den_n = 1'b1;
        cyc();
        host_clr_err = 1'b1;
        cyc();
        host_clr_err = 1'b0;

        // A long DEN_n pulse pops exactly one word.
        host_push(3'd0, 16'h1111);
        host_push(3'd0, 16'h2222);
        aout = 12'h000; den_n = 1'b0;
        repeat (20) cyc();
        check("long_den_data", 32'(din), 32'h1111);
        den_n = 1'b1;
        cyc();
        in_pulse(12'h000, 16'h2222, "long_den_next");
        check("long_den_no_underrun", 32'(in_underrun), 32'h0);

        // Push and pop on an empty input FIFO in the same cycle.
        aout = 12'h004; den_n = 1'b0;
        host_wr = 1'b1; host_wr_port = 3'd4; host_wdata = 16'hBEEF;
        cyc();
        host_wr = 1'b0;
        check("same_cycle_din",      32'(din),            32'h0);
        check("same_cycle_underrun", 32'(in_underrun[4]), 32'h1);
        check("same_cycle_not_full", 32'(in_full[4]),     32'h0);
        den_n = 1'b1;
        cyc();
        in_pulse(12'h004, 16'hBEEF, "same_cycle_stored");

        // Fill input FIFO 0; the fifth host push is dropped.
        for (int k = 1; k <= 5; k++) host_push(3'd0, 16'(k));
        check("in_full_port0", 32'(in_full), 32'h01);
        for (int k = 1; k <= 4; k++) in_pulse(12'h000, 16'(k), $sformatf("full_drain%0d", k));
        in_pulse(12'h000, 16'h0000, "full_fifth_dropped");

        // Both read strobes low: IN data (empty port 1 -> 0) wins over 7EE0.
        aout = 12'h001; men_n = 1'b0; den_n = 1'b0;
        cyc();
        check("both_strobes_din", 32'(din),    32'h0);
        check("both_strobes_oe",  32'(din_oe), 32'h1);
        men_n = 1'b1; den_n = 1'b1;
        cyc();

        // Host load coinciding with a TBLW commit to the same address.
        aout = 12'h050; dout = 16'hDEAD; we_n = 1'b0;
        cyc();
        we_n = 1'b1; pld_wr = 1'b1; pld_addr = 12'h050; pld_data = 16'hCAFE;
        cyc();
        pld_wr = 1'b0;
        fetch(12'h050, 16'hCAFE, "pld_beats_tblw");

        // Reset during a WE_n low pulse aborts the OUT commit.
        aout = 12'h003; dout = 16'h7777; we_n = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        check_reset("mid_we_reset");
        rst_n = 1'b1;
        cyc();
        we_n = 1'b1;
        cyc();
        cyc();
        check("mid_we_no_commit", 32'(out_empty), 32'(ALL_ONES));
        check("mid_we_no_overrun", 32'(out_overrun), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
